// File: rtl/lcd_text_feeder_if.sv
// Handshake bundle between the text feeder and the 4-bit HD44780 controller.
interface lcd_text_feeder_if;
    logic [7:0] lcd_char;
    logic       lcd_write_char;
    logic       lcd_home;
    logic       lcd_ready;

    modport master (output lcd_char, output lcd_write_char, output lcd_home, input lcd_ready);
    modport slave  (input lcd_char, input lcd_write_char, input lcd_home, output lcd_ready);
endinterface

// File: rtl/lcd_text_feeder.sv
// Byte FIFO feeding an HD44780 controller one character per ready handshake; newline becomes home.
// Optional LCD_AUTOHOME_EN: wrap to column 0 with a home command when the line is full.
module lcd_text_feeder #(
    parameter int         DEPTH   = 16,
    parameter int         COLS    = 16,
    parameter logic [7:0] NEWLINE = 8'h0A
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            data_in,
    input  logic                  push,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [4:0]            column,
    lcd_text_feeder_if.master     lcd
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] COLS_W = 5'(COLS);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
    logic        full_reg, empty_reg, overflow_reg;
    logic        full_next, empty_next;
    logic [1:0]  state_reg;
    logic [7:0]  char_reg;
    logic        write_reg, home_reg;
    logic [4:0]  column_reg, column_inc;
    logic [7:0]  head;
    logic        go, is_nl, wrap, pop, push_ok;

    // Head byte is needed in the same cycle to decide write vs. home.
    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign go    = (state_reg == ST_IDLE) && !empty_reg && lcd.lcd_ready;
    assign is_nl = (head == NEWLINE);

`ifdef LCD_AUTOHOME_EN
    assign wrap = go && !is_nl && (column_reg == COLS_W);
`else
    assign wrap = 1'b0;
`endif

    assign pop        = go && !wrap;
    assign push_ok    = push && (!full_reg || pop);
    assign column_inc = (column_reg == COLS_W) ? column_reg : column_reg + 5'd1;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_ok};
        rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
        empty_next  = (wr_ptr_next == rd_ptr_next);
        full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            state_reg    <= ST_IDLE;
            char_reg     <= 8'h00;
            write_reg    <= 1'b0;
            home_reg     <= 1'b0;
            column_reg   <= 5'd0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            full_reg   <= full_next;
            empty_reg  <= empty_next;
            if (push && full_reg && !pop) begin
                overflow_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (go) begin
                        if (wrap) begin
                            // Home without popping; the same byte goes out on the next pass.
                            home_reg   <= 1'b1;
                            column_reg <= 5'd0;
                        end else begin
                            char_reg <= head;
                            if (is_nl) begin
                                home_reg   <= 1'b1;
                                column_reg <= 5'd0;
                            end else begin
                                write_reg  <= 1'b1;
                                column_reg <= column_inc;
                            end
                        end
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    write_reg <= 1'b0;
                    home_reg  <= 1'b0;
                    state_reg <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!lcd.lcd_ready) begin
                        state_reg <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (lcd.lcd_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign full               = full_reg;
    assign empty              = empty_reg;
    assign overflow           = overflow_reg;
    assign column             = column_reg;
    assign lcd.lcd_char       = char_reg;
    assign lcd.lcd_write_char = write_reg;
    assign lcd.lcd_home       = home_reg;
endmodule

// File: tb/tb_lcd_text_feeder.sv
// Scoreboard bench for lcd_text_feeder with a simple busy-controller model.
module tb_lcd_text_feeder;
    localparam int         DEPTH = 16;
    localparam int         COLS  = 16;
    localparam logic [7:0] NL    = 8'h0A;

    typedef struct {
        bit         home;
        logic [7:0] ch;
        logic [4:0] col;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       push = 1'b0;
    logic       full, empty, overflow;
    logic [4:0] column;

    lcd_text_feeder_if lcd_bus ();

    lcd_text_feeder #(.DEPTH(DEPTH), .COLS(COLS), .NEWLINE(NL)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .push(push),
        .full(full), .empty(empty), .overflow(overflow), .column(column),
        .lcd(lcd_bus)
    );

    always #5 clk = ~clk;

    // Controller model: ready drops the cycle after a pulse, returns after busy_len cycles.
    logic ready_model = 1'b1;
    logic ctrl_hold = 1'b0;
    int   busy_len = 4;
    int   busy_cnt = 0;
    assign lcd_bus.lcd_ready = ready_model & ~ctrl_hold;

    always @(posedge clk) begin
        if (lcd_bus.lcd_write_char || lcd_bus.lcd_home) begin
            ready_model <= 1'b0;
            busy_cnt    <= busy_len;
        end else if (!ready_model) begin
            if (busy_cnt <= 1) ready_model <= 1'b1;
            else busy_cnt <= busy_cnt - 1;
        end
    end

    int  n_checks = 0;
    int  n_fail = 0;
    ev_t exp_q[$];
    int  model_col = 0;
    logic [7:0] model_last = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the display text rules applied to the accepted byte stream.
    task automatic gen(input logic [7:0] b);
        ev_t e;
        if (b == NL) begin
            model_col  = 0;
            model_last = b;
            e.home = 1'b1; e.ch = b; e.col = 5'd0;
            exp_q.push_back(e);
        end else begin
`ifdef LCD_AUTOHOME_EN
            if (model_col == COLS) begin
                model_col = 0;
                e.home = 1'b1; e.ch = model_last; e.col = 5'd0;
                exp_q.push_back(e);
            end
`endif
            model_last = b;
            model_col  = (model_col < COLS) ? model_col + 1 : COLS;
            e.home = 1'b0; e.ch = b; e.col = 5'(model_col);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on every pulse, checks hold and exclusivity rules.
    logic       rst_q = 1'b1;
    logic       prev_pulse = 1'b0;
    logic       hold_active = 1'b0;
    logic [7:0] hold_char = 8'h00;
    always @(posedge clk) rst_q <= reset;

    always @(negedge clk) begin
        ev_t e;
        logic pulse;
        pulse = lcd_bus.lcd_write_char | lcd_bus.lcd_home;
        if (rst_q) begin
            hold_active = 1'b0;
        end else begin
            if (pulse) begin
                check("no_overlap", {31'd0, lcd_bus.lcd_write_char & lcd_bus.lcd_home}, 32'd0);
                check("pulse_width", {31'd0, prev_pulse}, 32'd0);
                check("pulse_ready", {31'd0, lcd_bus.lcd_ready}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: write=%0b home=%0b char=%0h, expected none",
                             lcd_bus.lcd_write_char, lcd_bus.lcd_home, lcd_bus.lcd_char);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_home", {31'd0, lcd_bus.lcd_home}, {31'd0, e.home});
                    check("pulse_char", {24'd0, lcd_bus.lcd_char}, {24'd0, e.ch});
                    check("pulse_column", {27'd0, column}, {27'd0, e.col});
                    hold_char   = e.ch;
                    hold_active = 1'b1;
                end
            end else if (hold_active && !lcd_bus.lcd_ready) begin
                check("char_hold", {24'd0, lcd_bus.lcd_char}, {24'd0, hold_char});
            end
        end
        prev_pulse = pulse;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        model_col  = 0;
        model_last = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check("rst_column", {27'd0, column}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_char", {24'd0, lcd_bus.lcd_char}, 32'd0);
        check("rst_write", {31'd0, lcd_bus.lcd_write_char}, 32'd0);
        check("rst_home", {31'd0, lcd_bus.lcd_home}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic push_raw(input logic [7:0] b, input bit accept);
        @(negedge clk);
        data_in = b;
        push = 1'b1;
        if (accept) gen(b);
        @(posedge clk);
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int i;
        for (i = 0; i < 3000 && full; i++) @(negedge clk);
        if (full) check("push_wait_not_full", {31'd0, full}, 32'd0);
        else push_raw(b, 1'b1);
    endtask

    task automatic wait_drain();
        int stable = 0;
        for (int i = 0; i < 8000 && stable < 4; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && lcd_bus.lcd_ready && empty) stable++;
            else stable = 0;
        end
        check("drain_complete", {31'd0, stable >= 4}, 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        do_reset();

        // Basic handshake with a 200-cycle busy controller.
        busy_len = 200;
        repeat (8) @(negedge clk);
        push_raw(8'h41, 1'b1);
        check("lat_cycle1_nopulse", {31'd0, lcd_bus.lcd_write_char}, 32'd0);
        check("lat_cycle1_empty", {31'd0, empty}, 32'd0);
        @(negedge clk);
        check("lat_cycle2_pulse", {31'd0, lcd_bus.lcd_write_char}, 32'd1);
        @(negedge clk);
        check("lat_cycle3_nopulse", {31'd0, lcd_bus.lcd_write_char}, 32'd0);
        repeat (150) @(negedge clk);
        check("basic_char_held", {24'd0, lcd_bus.lcd_char}, 32'h41);
        check("basic_column", {27'd0, column}, 32'd1);
        wait_drain();

        // Newline becomes home.
        busy_len = 5;
        push_byte(8'h48);
        push_byte(NL);
        push_byte(8'h49);
        wait_drain();
        check("newline_column", {27'd0, column}, 32'd1);

        // Init hold and overflow.
        do_reset();
        ctrl_hold = 1'b1;
        busy_len = 4;
        for (int i = 0; i < DEPTH; i++) push_raw(8'h30 + 8'(i), 1'b1);
        check("ovf_full_at_depth", {31'd0, full}, 32'd1);
        check("ovf_not_yet", {31'd0, overflow}, 32'd0);
        push_raw(8'h7E, 1'b0);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        repeat (10) @(negedge clk);
        check("ovf_no_pulses", {27'd0, 5'(DEPTH - exp_q.size())}, 32'd0);
        ctrl_hold = 1'b0;
        wait_drain();
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Simultaneous push and pop while full.
        do_reset();
        ctrl_hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_raw(8'h61 + 8'(i % 20), 1'b1);
        check("pp_full_before", {31'd0, full}, 32'd1);
        @(negedge clk);
        ctrl_hold = 1'b0;
        data_in = 8'h5A;
        push = 1'b1;
        gen(8'h5A);
        @(posedge clk);
        @(negedge clk);
        push = 1'b0;
        check("pp_full_after", {31'd0, full}, 32'd1);
        check("pp_no_overflow", {31'd0, overflow}, 32'd0);
        wait_drain();

        // Line wrap behaviour over 17 printable bytes.
        do_reset();
        busy_len = 3;
        for (int i = 0; i < 17; i++) push_byte(8'h61 + 8'(i));
        wait_drain();
`ifdef LCD_AUTOHOME_EN
        check("wrap_column", {27'd0, column}, 32'd1);
`else
        check("wrap_column", {27'd0, column}, 32'd16);
`endif

        // Randomized bursts.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            busy_len = $urandom_range(2, 8);
            for (int j = 0, n = $urandom_range(1, 8); j < n; j++) begin
                b = ($urandom_range(0, 4) == 0) ? NL : 8'($urandom_range(32, 126));
                push_byte(b);
            end
            wait_drain();
            check("rand_column", {27'd0, column}, 32'(model_col));
        end

        // Reset while the controller is busy, with bytes still queued.
        busy_len = 200;
        for (int i = 0; i < 4; i++) push_byte(8'h21 + 8'(i));
        for (int i = 0; i < 400 && lcd_bus.lcd_ready; i++) @(negedge clk);
        check("mid_busy_seen", {31'd0, lcd_bus.lcd_ready}, 32'd0);
        do_reset();
        repeat (50) @(negedge clk);
        check("mid_no_pulse_empty", {31'd0, empty}, 32'd1);
        push_byte(8'h33);
        wait_drain();
        check("mid_column", {27'd0, column}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
